// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-stage definitions: NOP encoding, FSM state codes, PC-select codes, XLEN default.
package instr_fetch_unit_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_HOLD    = 2'd1,
    ST_DISCARD = 2'd2,
    ST_FAULT   = 2'd3
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_HOLD  = 2'd0,
    PC_INC   = 2'd1,
    PC_REDIR = 2'd2,
    PC_PEND  = 2'd3
  } pc_sel_e;

  function automatic logic is_aligned(input logic [1:0] low_bits);
    return low_bits == 2'b00;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_pc_reg.sv
// Fetch PC register with +4 increment, redirect/pending-target mux and redirect alignment check.
module fetch_pc_reg
  import instr_fetch_unit_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc,
  input  pc_sel_e         i_pc_sel,
  input  logic            i_pend_load,
  output logic            o_redir_ok,
  output logic            o_redir_bad,
  output logic [XLEN-1:0] o_pc
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pend_pc;
  logic [XLEN-1:0] w_pc_next;

  assign o_redir_ok  = i_redirect_valid &&  is_aligned(i_redirect_pc[1:0]);
  assign o_redir_bad = i_redirect_valid && !is_aligned(i_redirect_pc[1:0]);
  assign o_pc        = r_pc;

  // Increment wraps naturally at 2^XLEN.
  always_comb begin
    w_pc_next = r_pc;
    unique case (i_pc_sel)
      PC_HOLD:  w_pc_next = r_pc;
      PC_INC:   w_pc_next = r_pc + PC_STEP;
      PC_REDIR: w_pc_next = i_redirect_pc;
      PC_PEND:  w_pc_next = r_pend_pc;
      default:  w_pc_next = r_pc;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc      <= RESET_PC;
      r_pend_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
      if (i_pend_load) r_pend_pc <= i_redirect_pc;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: issues word reads over req/ack and hands instructions to decode
// over valid/ready, with branch redirects and misaligned-target fault handling.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_ack,
  input  logic [31:0]     i_imem_rdata,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_instr_valid,
  output logic [31:0]     o_instr,
  output logic [XLEN-1:0] o_instr_pc,
  input  logic            i_instr_ready,
  output logic            o_fetch_fault
);

  fetch_state_e    r_state;
  logic            r_instr_valid;
  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_instr_pc;
  logic            r_fetch_fault;
  logic            r_pend_fault;

  logic            w_redir_ok;
  logic            w_redir_bad;
  logic [XLEN-1:0] w_pc;
  pc_sel_e         w_pc_sel;
  logic            w_pend_load;

  fetch_pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_redirect_valid (i_redirect_valid),
    .i_redirect_pc    (i_redirect_pc),
    .i_pc_sel         (w_pc_sel),
    .i_pend_load      (w_pend_load),
    .o_redir_ok       (w_redir_ok),
    .o_redir_bad      (w_redir_bad),
    .o_pc             (w_pc)
  );

  // DISCARD keeps presenting the old address: the pending target lives in the pc sub-module.
  assign o_imem_req    = !i_rst && (r_state == ST_FETCH || r_state == ST_DISCARD);
  assign o_imem_addr   = w_pc;
  assign o_instr_valid = r_instr_valid;
  assign o_instr       = r_instr;
  assign o_instr_pc    = r_instr_pc;
  assign o_fetch_fault = r_fetch_fault;

  always_comb begin
    w_pc_sel    = PC_HOLD;
    w_pend_load = 1'b0;
    unique case (r_state)
      ST_FETCH: begin
        if (w_redir_ok) begin
          if (i_imem_ack) w_pc_sel = PC_REDIR;
          else            w_pend_load = 1'b1;
        end
      end
      ST_HOLD: begin
        if (w_redir_ok)                         w_pc_sel = PC_REDIR;
        else if (!w_redir_bad && i_instr_ready) w_pc_sel = PC_INC;
      end
      ST_DISCARD: begin
        w_pend_load = w_redir_ok;
        if (i_imem_ack) w_pc_sel = w_redir_ok ? PC_REDIR : PC_PEND;
      end
      ST_FAULT: begin
        if (w_redir_ok) w_pc_sel = PC_REDIR;
      end
      default: w_pc_sel = PC_HOLD;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_FETCH;
      r_instr_valid <= 1'b0;
      r_instr       <= NOP_INSTR;
      r_instr_pc    <= RESET_PC;
      r_fetch_fault <= 1'b0;
      r_pend_fault  <= 1'b0;
    end else begin
      // The fault flag follows the most recent redirect, even while a request drains.
      if (w_redir_ok)       r_fetch_fault <= 1'b0;
      else if (w_redir_bad) r_fetch_fault <= 1'b1;
      if (w_redir_bad)      r_instr_valid <= 1'b0;

      unique case (r_state)
        ST_FETCH: begin
          if (i_imem_ack) begin
            if (w_redir_bad) begin
              r_state <= ST_FAULT;
            end else if (!w_redir_ok) begin
              r_state       <= ST_HOLD;
              r_instr       <= i_imem_rdata;
              r_instr_pc    <= w_pc;
              r_instr_valid <= 1'b1;
            end
          end else if (i_redirect_valid) begin
            r_state      <= ST_DISCARD;
            r_pend_fault <= w_redir_bad;
          end
        end
        ST_HOLD: begin
          if (w_redir_bad) begin
            r_state <= ST_FAULT;
          end else if (w_redir_ok || i_instr_ready) begin
            r_state       <= ST_FETCH;
            r_instr_valid <= 1'b0;
          end
        end
        ST_DISCARD: begin
          if (i_redirect_valid) r_pend_fault <= w_redir_bad;
          if (i_imem_ack) begin
            r_state <= (w_redir_bad || (r_pend_fault && !w_redir_ok)) ? ST_FAULT : ST_FETCH;
          end
        end
        ST_FAULT: begin
          if (w_redir_ok) r_state <= ST_FETCH;
        end
        default: r_state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed and randomized checks of instr_fetch_unit against a transaction-level program-order model.
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        imem_req, imem_ack, redirect_valid, instr_valid, instr_ready, fetch_fault;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, instr, instr_pc;

  logic        req2, ack2, valid2, ready2, fault2;
  logic [31:0] addr2, rdata2, instr2, pc2;
  logic        redir_v2;
  logic [31:0] redir_pc2;

  instr_fetch_unit dut (
    .i_clk(clk), .i_rst(rst),
    .o_imem_req(imem_req), .o_imem_addr(imem_addr),
    .i_imem_ack(imem_ack), .i_imem_rdata(imem_rdata),
    .i_redirect_valid(redirect_valid), .i_redirect_pc(redirect_pc),
    .o_instr_valid(instr_valid), .o_instr(instr), .o_instr_pc(instr_pc),
    .i_instr_ready(instr_ready), .o_fetch_fault(fetch_fault)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .i_clk(clk), .i_rst(rst),
    .o_imem_req(req2), .o_imem_addr(addr2),
    .i_imem_ack(ack2), .i_imem_rdata(rdata2),
    .i_redirect_valid(redir_v2), .i_redirect_pc(redir_pc2),
    .o_instr_valid(valid2), .o_instr(instr2), .o_instr_pc(pc2),
    .i_instr_ready(ready2), .o_fetch_fault(fault2)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] exp_pc;
  bit          exp_fault;
  bit          mem_active;
  int          mem_wait;
  int          lat_min, lat_max;
  bit          prev_req_pend;
  logic [31:0] prev_addr;
  int          delivered;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h0F0F_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: check current outputs, drive this cycle's inputs, update model.
  task automatic step(input bit rdy, input bit rv, input logic [31:0] rpc);
    if (prev_req_pend) begin
      chk("req_held_until_ack", 32'(imem_req), 32'd1);
      chk("addr_held_until_ack", imem_addr, prev_addr);
    end
    if (imem_req) chk("addr_word_aligned", 32'(imem_addr[1:0]), 32'd0);
    chk("fetch_fault", 32'(fetch_fault), 32'(exp_fault));
    if (instr_valid) begin
      chk("no_req_while_valid", 32'(imem_req), 32'd0);
      chk("instr_pc_order", instr_pc, exp_pc);
      chk("instr_data", instr, memf(instr_pc));
    end
    if (exp_fault) chk("no_valid_in_fault", 32'(instr_valid), 32'd0);

    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    if (imem_req) begin
      if (!mem_active) begin
        mem_active = 1'b1;
        mem_wait   = $urandom_range(lat_max, lat_min);
      end
      if (mem_wait == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = memf(imem_addr);
        mem_active = 1'b0;
      end else begin
        mem_wait--;
      end
    end else begin
      mem_active = 1'b0;
    end
    prev_req_pend  = imem_req && !imem_ack;
    prev_addr      = imem_addr;
    instr_ready    = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;

    if (rv) begin
      if (rpc[1:0] == 2'b00) begin
        exp_pc    = rpc;
        exp_fault = 1'b0;
      end else begin
        exp_fault = 1'b1;
      end
    end else if (instr_valid && rdy) begin
      exp_pc = exp_pc + 32'd4;
      delivered++;
    end
    @(negedge clk);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 20; i++) begin
      if (instr_valid) break;
      step(1'b0, 1'b0, 32'h0);
    end
    chk("wait_valid_timeout", 32'(instr_valid), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_ack = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    ack2 = 1'b0; rdata2 = 32'h0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr_nop", instr, 32'h0000_0013);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_fault", 32'(fetch_fault), 32'd0);
    chk("rst_wrap_instr_pc", pc2, 32'hFFFF_FFFC);
    rst = 1'b0;
    exp_pc = 32'h0; exp_fault = 1'b0; mem_active = 1'b0; mem_wait = 0;
    prev_req_pend = 1'b0; prev_addr = 32'h0;
    #1;
    chk("post_rst_req", 32'(imem_req), 32'd1);
    chk("post_rst_addr", imem_addr, 32'h0);
  endtask

  initial begin
    logic [31:0] saved_instr;
    logic [31:0] wrap_addrs [2];
    int          n_wrap;
    int          rnd_deliv;
    logic [31:0] tgt;

    ready2 = 1'b1; redir_v2 = 1'b0; redir_pc2 = 32'h0;
    lat_min = 1; lat_max = 1; delivered = 0;
    @(negedge clk);

    // 1: back-to-back fetch with 1-cycle memory latency and decode always ready
    do_reset();
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 32'h0);
    chk("t1_delivered", 32'(delivered), 32'd3);
    chk("t1_next_req", 32'(imem_req), 32'd1);
    chk("t1_next_addr", imem_addr, 32'hC);

    // 2: decode stalls for 5 cycles
    wait_valid();
    saved_instr = instr;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 32'h0);
      chk("t2_instr_stable", instr, saved_instr);
      chk("t2_pc_stable", instr_pc, 32'hC);
      chk("t2_no_req", 32'(imem_req), 32'd0);
    end
    step(1'b1, 1'b0, 32'h0);

    // 3: redirect while a 3-cycle-latency read is outstanding
    lat_min = 3; lat_max = 3;
    chk("t3_req_pending", 32'(imem_req), 32'd1);
    step(1'b0, 1'b1, 32'h100);
    for (int i = 0; i < 10; i++) begin
      if (imem_req && imem_addr == 32'h100) break;
      step(1'b0, 1'b0, 32'h0);
    end
    chk("t3_redirect_addr", imem_addr, 32'h100);
    wait_valid();
    chk("t3_instr_pc", instr_pc, 32'h100);

    // 4: redirect beats a same-cycle ready handshake
    lat_min = 1; lat_max = 1;
    step(1'b1, 1'b1, 32'h200);
    wait_valid();
    chk("t4_instr_pc", instr_pc, 32'h200);
    chk("t4_instr", instr, memf(32'h200));

    // 5: misaligned redirect faults, aligned redirect recovers
    step(1'b0, 1'b1, 32'h102);
    chk("t5_fault_next", 32'(fetch_fault), 32'd1);
    chk("t5_valid_clr", 32'(instr_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("t5_no_req", 32'(imem_req), 32'd0);
      step(1'b1, 1'b0, 32'h0);
    end
    step(1'b0, 1'b1, 32'h40);
    chk("t5_fault_clr", 32'(fetch_fault), 32'd0);
    chk("t5_req", 32'(imem_req), 32'd1);
    chk("t5_addr", imem_addr, 32'h40);
    wait_valid();
    chk("t5_instr_pc", instr_pc, 32'h40);
    step(1'b1, 1'b0, 32'h0);

    // 6a: reset in the middle of a discard
    lat_min = 3; lat_max = 3;
    step(1'b0, 1'b1, 32'h300);
    step(1'b0, 1'b0, 32'h0);
    chk("t6_in_discard_addr", imem_addr, 32'h44);
    do_reset();

    // 6b: PC wrap from 0xFFFF_FFFC to 0 with a zero-latency memory
    lat_min = 0; lat_max = 0;
    n_wrap = 0;
    for (int i = 0; i < 8; i++) begin
      ack2   = req2;
      rdata2 = memf(addr2);
      if (req2 && n_wrap < 2) begin
        wrap_addrs[n_wrap] = addr2;
        n_wrap++;
      end
      if (i == 1) chk("t6_wrap_instr_pc", pc2, 32'hFFFF_FFFC);
      step(1'b1, 1'b0, 32'h0);
    end
    ack2 = 1'b0;
    chk("t6_wrap_count", 32'(n_wrap), 32'd2);
    chk("t6_wrap_first", wrap_addrs[0], 32'hFFFF_FFFC);
    chk("t6_wrap_second", wrap_addrs[1], 32'h0);

    // Randomized traffic: latency, ready, aligned/misaligned redirects, near-wrap targets
    lat_min = 0; lat_max = 3;
    do_reset();
    rnd_deliv = delivered;
    for (int i = 0; i < 3000; i++) begin
      bit rv;
      rv  = ($urandom_range(99, 0) < 5);
      tgt = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(15, 0)))
                                        : 32'($urandom_range(16'hFFFF, 0));
      if ($urandom_range(3, 0) != 0) tgt[1:0] = 2'b00;
      step($urandom_range(9, 0) < 7, rv, tgt);
    end
    chk("rand_progress", 32'(delivered - rnd_deliv > 50), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
